// File: rtl/adc_pkg.sv
// Shared types for the ADC capture scheduler.
// Holds the frame FSM state encoding.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    CAPTURE,
    FLUSH
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner.
// The pointer only moves when the caller accepts a grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] index
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] ptr;
  logic [IW-1:0] pos;
  logic          found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = IW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        index      = pos;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (index == IW'(NUM_REQ - 1)) ? '0 : index + 1'b1;
    end
  end

endmodule

// File: rtl/adc_capture_scheduler.sv
// Schedules ADC frame captures between requesters and
// routes samples through a one-entry output register.
module adc_capture_scheduler
  import adc_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 12,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       timeout_err,
  output logic                       busy,
  output logic                       smp_enable,
  output logic                       smp_ready,
  input  logic [DATA_WIDTH-1:0]      smp_data,
  input  logic                       smp_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(NUM_REQ)-1:0] out_owner
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  state_t state;
  state_t state_n;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic [IW-1:0]      owner;
  logic               advance;
  logic               arb_hit;
  logic [LEN_W-1:0]   sel_len;
  logic [LEN_W-1:0]   cnt;
  logic [WW-1:0]      wdog;
  logic               inflight;
  logic               in_cap;
  logic               cap_valid;
  logic               last_smp;
  logic               wd_expire;
  logic               flush_ok;
  logic               out_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .grant   (arb_grant),
    .index   (arb_idx)
  );

  assign sel_len   = req_len[int'(arb_idx)*LEN_W +: LEN_W];
  assign arb_hit   = |arb_grant;
  assign in_cap    = (state == CAPTURE);
  assign out_fire  = out_valid && out_ready;
  assign flush_ok  = !out_valid || out_ready;
  assign cap_valid = in_cap && smp_valid;
  assign last_smp  = cap_valid && (cnt == LEN_W'(1));
  assign wd_expire = in_cap && !smp_valid && (wdog == WD_LAST);

  assign busy       = (state != IDLE);
  assign smp_enable = in_cap;
  // One conversion outstanding at most, so a returning sample
  // always finds the output register free.
  assign smp_ready  = in_cap && !inflight && flush_ok
                      && (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    advance = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) state_n = ARB;
      end
      ARB: begin
        advance = arb_hit;
        if (!arb_hit || sel_len == '0) state_n = IDLE;
        else                            state_n = CAPTURE;
      end
      CAPTURE: begin
        if (wd_expire)     state_n = IDLE;
        else if (last_smp) state_n = FLUSH;
      end
      FLUSH: begin
        if (flush_ok) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      done        <= '0;
      timeout_err <= 1'b0;
      owner       <= '0;
      cnt         <= '0;
      wdog        <= '0;
      inflight    <= 1'b0;
    end else begin
      done        <= '0;
      timeout_err <= 1'b0;
      unique case (state)
        ARB: begin
          if (arb_hit) begin
            if (sel_len == '0) begin
              done <= arb_grant;
            end else begin
              grant    <= arb_grant;
              owner    <= arb_idx;
              cnt      <= sel_len;
              wdog     <= '0;
              inflight <= 1'b0;
            end
          end
        end
        CAPTURE: begin
          if (smp_ready)      inflight <= 1'b1;
          else if (smp_valid) inflight <= 1'b0;
          if (smp_valid) begin
            wdog <= '0;
            if (cnt != '0) cnt <= cnt - LEN_W'(1);
          end else if (wd_expire) begin
            timeout_err <= 1'b1;
            done        <= grant;
            grant       <= '0;
            cnt         <= '0;
            wdog        <= '0;
            inflight    <= 1'b0;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        FLUSH: begin
          if (flush_ok) begin
            done  <= grant;
            grant <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // An aborted frame still drains its held beat, marked last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_owner <= '0;
    end else if (cap_valid) begin
      out_valid <= 1'b1;
      out_last  <= (cnt == LEN_W'(1));
      out_data  <= smp_data;
      out_owner <= owner;
    end else if (wd_expire && out_valid && !out_ready) begin
      out_last <= 1'b1;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_n && cap_valid) begin
      assert (flush_ok);
    end
  end

endmodule

// File: tb/tb_adc_capture_scheduler.sv
// Directed + randomized bench for adc_capture_scheduler
// with a frame-level round-robin reference model.
module tb_adc_capture_scheduler;

  localparam int N  = 4;
  localparam int DW = 12;
  localparam int LW = 16;
  localparam int TO = 100;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] owner;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic          timeout_err;
  logic          busy;
  logic          smp_enable;
  logic          smp_ready;
  logic [DW-1:0] smp_data = '0;
  logic          smp_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic [IW-1:0] out_owner;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  beat_t beats[$];
  beat_t exp_beats[$];
  logic [N-1:0] dones[$];
  int done_cyc[$];
  int to_cyc[$];
  int exp_order[$];
  int last_valid_cyc = 0;
  int ready_viol = 0;
  bit en_seen = 1'b0;
  int smp_budget = 1000000;
  logic [DW-1:0] smp_next = '0;
  int rr_next = 0;

  adc_capture_scheduler #(
    .NUM_REQ        (N),
    .DATA_WIDTH     (DW),
    .LEN_W          (LW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_len     (req_len),
    .grant       (grant),
    .done        (done),
    .timeout_err (timeout_err),
    .busy        (busy),
    .smp_enable  (smp_enable),
    .smp_ready   (smp_ready),
    .smp_data    (smp_data),
    .smp_valid   (smp_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .out_owner   (out_owner)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (out_valid && out_ready)
        beats.push_back('{out_owner, out_last, out_data});
      if (|done) begin
        dones.push_back(done);
        done_cyc.push_back(cyc);
      end
      if (timeout_err) to_cyc.push_back(cyc);
      if (smp_valid) last_valid_cyc = cyc;
      if (smp_ready && out_valid && !out_ready) ready_viol++;
      if (smp_enable) en_seen = 1'b1;
    end
  end

  // ADC model: one conversion per accepted ready, 1..3 cycles.
  initial forever begin
    @(negedge clk);
    if (smp_ready) begin
      @(posedge clk);
      if (smp_budget > 0) begin
        smp_budget--;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        smp_data  = smp_next;
        smp_valid = 1'b1;
        smp_next  = smp_next + 1'b1;
        @(posedge clk);
        #1;
        smp_valid = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1, "stuck");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit rnd);
    @(posedge clk);
    #1;
    if (|done) req = req & ~done;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_dones(input int n, input int budget,
                            input bit rnd);
    int k;
    k = 0;
    while (dones.size() < n && k < budget) begin
      tick(rnd);
      k++;
    end
    chk("dones_reached", 32'(dones.size() >= n), 1);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (beats.size() < n && k < budget) begin
      tick(1'b0);
      k++;
    end
    chk("beats_reached", 32'(beats.size() >= n), 1);
  endtask

  task automatic set_len(input int i, input int len);
    req_len[i*LW +: LW] = LW'(len);
  endtask

  task automatic clear_logs();
    beats.delete();
    exp_beats.delete();
    dones.delete();
    done_cyc.delete();
    to_cyc.delete();
    exp_order.delete();
  endtask

  task automatic add_frame(input int owner, input int len,
                           inout logic [DW-1:0] d);
    for (int b = 0; b < len; b++) begin
      exp_beats.push_back('{IW'(owner), (b == len - 1), d});
      d = d + 1'b1;
    end
  endtask

  // Requesters held until served: visit active ones in
  // index order starting after the previous winner.
  task automatic model_round(input logic [N-1:0] act,
                             input int lens[N],
                             input logic [DW-1:0] base);
    logic [DW-1:0] d;
    d = base;
    exp_order.delete();
    for (int s = 0; s < N; s++) begin
      int i;
      i = (rr_next + s) % N;
      if (act[i]) begin
        exp_order.push_back(i);
        add_frame(i, lens[i], d);
      end
    end
    if (exp_order.size() > 0)
      rr_next = (exp_order[exp_order.size() - 1] + 1) % N;
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_count"}, beats.size(), exp_beats.size());
    for (int i = 0; i < exp_beats.size() && i < beats.size(); i++)
      chk(tag, 32'(beats[i]), 32'(exp_beats[i]));
    beats.delete();
    exp_beats.delete();
  endtask

  task automatic check_order(input string tag);
    chk({tag, "_count"}, dones.size(), exp_order.size());
    for (int k = 0; k < exp_order.size() && k < dones.size(); k++)
      chk(tag, 32'(dones[k]), 32'(1) << exp_order[k]);
    dones.delete();
    done_cyc.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_tmo"}, 32'(timeout_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_en"}, 32'(smp_enable), 0);
    chk({tag, "_srdy"}, 32'(smp_ready), 0);
    chk({tag, "_ovalid"}, 32'(out_valid), 0);
    chk({tag, "_olast"}, 32'(out_last), 0);
    chk({tag, "_odata"}, 32'(out_data), 0);
    chk({tag, "_oowner"}, 32'(out_owner), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    rr_next = 0;
    repeat (5) tick(1'b0);
    clear_logs();
  endtask

  initial begin
    int lens[N];
    int held;
    int req_cyc;
    logic [N-1:0] act;
    logic [DW-1:0] base;

    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("por");
    rst_n = 1'b1;
    repeat (3) tick(1'b0);

    // single frame of four samples to requester 1
    clear_logs();
    smp_next = 12'h123;
    set_len(1, 4);
    out_ready = 1'b1;
    req = 4'b0010;
    wait_dones(1, 300, 1'b0);
    lens = '{0, 4, 0, 0};
    model_round(4'b0010, lens, 12'h123);
    check_beats("s1_beat");
    repeat (4) tick(1'b0);
    chk("s1_busy", 32'(busy), 0);
    check_order("s1_done");

    // all four requesting, two samples each, from reset
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_len(i, 2);
      lens[i] = 2;
    end
    smp_next = 12'h200;
    out_ready = 1'b1;
    req = 4'b1111;
    wait_dones(4, 600, 1'b0);
    model_round(4'b1111, lens, 12'h200);
    check_beats("s2_beat");
    check_order("s2_order");

    // output stalled for 50 cycles mid-frame
    clear_logs();
    set_len(3, 6);
    lens = '{0, 0, 0, 6};
    smp_next = 12'h300;
    out_ready = 1'b1;
    req = 4'b1000;
    wait_beats(2, 200);
    out_ready = 1'b0;
    held = beats.size();
    repeat (50) tick(1'b0);
    chk("s3_srdy_stall", 32'(smp_ready), 0);
    chk("s3_held_valid", 32'(out_valid), 1);
    chk("s3_no_beats", beats.size(), held);
    out_ready = 1'b1;
    wait_dones(1, 300, 1'b0);
    model_round(4'b1000, lens, 12'h300);
    check_beats("s3_beat");
    check_order("s3_done");
    chk("s3_ready_viol", ready_viol, 0);

    // sampler answers only the first of three conversions
    clear_logs();
    set_len(0, 3);
    smp_next = 12'h400;
    smp_budget = 1;
    out_ready = 1'b0;
    req = 4'b0001;
    wait_dones(1, TO + 100, 1'b0);
    chk("s4_tmo_count", to_cyc.size(), 1);
    chk("s4_tmo_time", (to_cyc.size() > 0) ? to_cyc[0] : -1,
        last_valid_cyc + TO + 1);
    chk("s4_done_time", (done_cyc.size() > 0) ? done_cyc[0] : -1,
        (to_cyc.size() > 0) ? to_cyc[0] : -2);
    chk("s4_done", (dones.size() > 0) ? 32'(dones[0]) : 0, 1);
    chk("s4_busy", 32'(busy), 0);
    chk("s4_en", 32'(smp_enable), 0);
    chk("s4_no_beat_yet", beats.size(), 0);
    out_ready = 1'b1;
    wait_beats(1, 20);
    repeat (3) tick(1'b0);
    exp_beats.push_back('{IW'(0), 1'b1, 12'h400});
    check_beats("s4_beat");
    smp_budget = 1000000;
    rr_next = 1;

    // zero-length request completes without capture
    clear_logs();
    en_seen = 1'b0;
    set_len(2, 0);
    req = 4'b0100;
    req_cyc = cyc + 1;
    wait_dones(1, 20, 1'b0);
    chk("s5_done_time", (done_cyc.size() > 0) ? done_cyc[0] : -1,
        req_cyc + 2);
    chk("s5_done", (dones.size() > 0) ? 32'(dones[0]) : 0, 4);
    chk("s5_no_enable", 32'(en_seen), 0);
    chk("s5_no_beats", beats.size(), 0);
    rr_next = 3;

    // reset pulsed during capture
    clear_logs();
    set_len(1, 8);
    smp_next = 12'h600;
    out_ready = 1'b1;
    req = 4'b0010;
    wait_beats(2, 200);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("s6_rst");
    req = '0;
    repeat (3) tick(1'b0);
    rst_n = 1'b1;
    repeat (8) tick(1'b0);
    chk("s6_no_done", dones.size(), 0);
    chk("s6_busy", 32'(busy), 0);
    rr_next = 0;
    clear_logs();

    // randomized request sets, lengths and output backpressure
    for (int r = 0; r < 10; r++) begin
      act = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        lens[i] = $urandom_range(0, 5);
        set_len(i, lens[i]);
      end
      base = DW'($urandom);
      smp_next = base;
      req = act;
      wait_dones($countones(act), 800, 1'b1);
      out_ready = 1'b1;
      repeat (3) tick(1'b0);
      model_round(act, lens, base);
      check_beats("rnd_beat");
      check_order("rnd_order");
      clear_logs();
    end
    chk("ready_viol", ready_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_capture_scheduler.md
ADC_CAPTURE_SCHEDULER -- requirements
Module: adc_capture_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of capture requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 12, sample width.
REQ-003 Parameter LEN_W, default 16, width of a requested frame length.
REQ-004 Parameter TIMEOUT_CYCLES, default 4096, maximum clk cycles between consecutive samples during capture.
REQ-005 clk  in  1  single clock; all logic is rising-edge clocked on clk.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req  in  NUM_REQ  per-requester capture request level.
REQ-008 req_len  in  NUM_REQ*LEN_W  per-requester frame length in samples, slice i at [i*LEN_W +: LEN_W].
REQ-009 grant  out  NUM_REQ  one-hot owner of the current frame; zero when idle.
REQ-010 done  out  NUM_REQ  one-cycle completion pulse to the owner.
REQ-011 timeout_err  out  1  one-cycle pulse when a frame is aborted by timeout.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 smp_enable  out  1  drives the sampler enable.
REQ-014 smp_ready  out  1  drives the sampler ready; permits one conversion.
REQ-015 smp_data  in  DATA_WIDTH  sampler output data.
REQ-016 smp_valid  in  1  sampler one-cycle data strobe; has no backpressure.
REQ-017 out_data  out  DATA_WIDTH  routed sample.
REQ-018 out_valid, out_ready  out/in  1 each  valid/ready output handshake.
REQ-019 out_last  out  1  marks the final sample of a frame.
REQ-020 out_owner  out  $clog2(NUM_REQ)  index of the requester owning out_data.

Function
REQ-021 The FSM SHALL have the states IDLE, ARB, CAPTURE and FLUSH.
REQ-022 IDLE -> ARB SHALL occur when any req bit is high.
REQ-023 ARB SHALL take exactly one cycle and grant round-robin, starting the search at (last owner + 1) mod NUM_REQ; after reset the search SHALL start at requester 0.
REQ-024 In ARB, a selected requester with req_len = 0 SHALL receive a done pulse on the next cycle, with no capture, and the FSM SHALL return to IDLE.
REQ-025 Otherwise the FSM SHALL latch the owner's req_len into a down-counter, assert grant and enter CAPTURE.
REQ-026 smp_enable SHALL be high only in CAPTURE.
REQ-027 smp_ready SHALL be high in CAPTURE only while the output register is empty, or is being emptied this cycle, and the remaining count excluding in-flight samples is non-zero.
REQ-028 Each smp_valid in CAPTURE SHALL load the output register, set out_valid and decrement the counter.
REQ-029 out_last SHALL be set when the counter reaches 0.
REQ-030 On the sample with out_last set, the FSM SHALL move to FLUSH.
REQ-031 out_valid and out_data SHALL hold stable until out_ready is high.
REQ-032 An smp_valid arriving while the output register is full SHALL never occur by construction; an assertion SHALL check for it.
REQ-033 FLUSH SHALL wait for the last output transfer, then pulse done[owner], clear grant and return to IDLE.
REQ-034 A watchdog counter SHALL reset on every smp_valid and on CAPTURE entry.
REQ-035 If the watchdog reaches TIMEOUT_CYCLES in CAPTURE, the block SHALL pulse timeout_err and done[owner], drop smp_enable, discard the remainder of the frame and return to IDLE; any pending output beat SHALL still drain, with out_last forced high on it.
REQ-036 Deassertion of req by the owner during CAPTURE SHALL be ignored; the frame completes.
REQ-037 req_len changes after ARB SHALL be ignored.
REQ-038 Counter arithmetic SHALL be LEN_W bits wide and never wrap below 0.

Reset
REQ-039 While rst_n is low, the block SHALL set: state IDLE, grant 0, done 0, timeout_err 0, busy 0, smp_enable 0, smp_ready 0, out_valid 0, out_last 0, out_data 0, out_owner 0, counters 0, round-robin pointer 0.
REQ-040 A reset mid-frame SHALL abort the frame without a done pulse.
REQ-041 The sampler SHALL observe enable low on the first clk edge after reset assertion.

Structure
REQ-042 The FSM state encodings SHALL live in the shared package adc_pkg.
REQ-043 The round-robin arbiter SHALL be one sub-module, rr_arbiter (NUM_REQ, req, advance -> one-hot grant, index).

Verification
REQ-044 Scenario 1: req[1]=1, req_len=4, sampler model returns 0x123..0x126, out_ready=1 -> four beats with out_owner=1, out_last on 0x126, then one done[1] pulse and busy=0.
REQ-045 Scenario 2: req=4'b1111, all req_len=2 -> grants in order 0,1,2,3; each frame has exactly 2 beats.
REQ-046 Scenario 3: out_ready=0 for 50 cycles mid-frame -> smp_ready stays low, no sample lost, and the data sequence is intact.
REQ-047 Scenario 4: sampler stops after 1 of 3 samples -> timeout_err and done pulse TIMEOUT_CYCLES after the last valid; 1 beat is output with out_last=1.
REQ-048 Scenario 5: req[2]=1, req_len=0 -> done[2] 2 cycles after req, with no smp_enable.
REQ-049 Scenario 6: rst_n pulsed low during CAPTURE -> all outputs return to reset values immediately, with no done pulse.
